// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access size codes, load/store FSM encoding
// and the byte-offset mask.
package cpu_pkg;

    localparam logic [1:0] SZ_WORD  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_BYTE  = 2'b10;
    localparam logic [1:0] SZ_RSVD  = 2'b11;
    localparam logic [1:0] OFF_MASK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Reserved size never aligns, so it reports as an error too.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] off);
        logic bad;
        case (size)
            SZ_WORD: bad = (off & OFF_MASK) != 2'b00;
            SZ_HALF: bad = off[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Lane extraction and merge for big-endian sub-word accesses:
// byte offset 0 lives in bits [31:24].
module mem_lane_mux
    import cpu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_pos;
    logic [31:0] half_pos;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Shift that brings the addressed lane down to bit 0.
    assign byte_sh  = {~offset, 3'b000};
    assign half_sh  = {~offset[1], 4'b0000};
    assign byte_pos = word >> byte_sh;
    assign half_pos = word >> half_sh;
    assign lane_b   = byte_pos[7:0];
    assign lane_h   = half_pos[15:0];

    always_comb begin
        load_val   = word;
        store_word = wdata;
        case (size)
            SZ_HALF: begin
                load_val   = {{16{sign & lane_h[15]}}, lane_h};
                store_word = (word & ~(32'h0000_ffff << half_sh))
                           | ({16'h0000, wdata[15:0]} << half_sh);
            end
            SZ_BYTE: begin
                load_val   = {{24{sign & lane_b[7]}}, lane_b};
                store_word = (word & ~(32'h0000_00ff << byte_sh))
                           | ({24'h000000, wdata[7:0]} << byte_sh);
            end
            default: begin
                load_val   = word;
                store_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store responder between the control unit and Memoria:
// req/ack handshake, read-modify-write for sub-word stores.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    state_t next;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sign_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic              bad;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;

    assign bad      = misaligned(size, addr[1:0]);
    assign mem_addr = {addr_q[ADDR_W-1:2], addr_q[1:0] & ~OFF_MASK};

    mem_lane_mux u_lane (
        .word       (mem_rdata),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .sign       (sign_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (bad) begin
                        next = ST_DONE;
                    end else if (we && size == SZ_WORD) begin
                        next = ST_WRITE;
                    end else begin
                        next = ST_READ;
                    end
                end
            end
            ST_READ:  next = ST_WAIT;
            ST_WAIT:  next = we_q ? ST_WRITE : ST_DONE;
            ST_WRITE: next = ST_DONE;
            ST_DONE:  next = ST_IDLE;
            default:  next = ST_IDLE;
        endcase
    end

    always_comb begin
        ack    = (state == ST_DONE);
        err    = (state == ST_DONE) && err_q;
        mem_wr = (state == ST_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            size_q    <= SZ_WORD;
            we_q      <= 1'b0;
            sign_q    <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rdata     <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        size_q  <= size;
                        we_q    <= we;
                        sign_q  <= sign;
                        wdata_q <= wdata;
                        err_q   <= bad;
                        if (we && size == SZ_WORD) begin
                            mem_wdata <= wdata;
                        end
                    end
                end
                ST_WAIT: begin
                    if (we_q) begin
                        mem_wdata <= store_word;
                    end else begin
                        rdata <= load_val;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array model
// of memory and the handshake timing rules.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign      (sign),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = (32'(i) * 32'h9e37_79b9) ^ 32'h5a5a_0000;
        if (i == 32'h40) w = 32'h8899_aabb;
        return w;
    endfunction

    // Memoria: one-cycle synchronous read, word indexed.
    logic [31:0] mem [0:255];
    initial begin
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    // Expectations for the transaction in flight.
    logic        exp_err;
    logic        exp_we;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_rdata;
    logic [31:0] exp_wword;
    logic [31:0] exp_base;
    logic        lit_en;
    logic        lit_err;
    int          lit_lat;
    logic [31:0] lit_val;
    int          start_id = 0;
    int          done_id = 0;
    bit          rst_q = 1'b0;

    always @(posedge clk) rst_q <= reset;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    bit run = 1'b0;
    int tcyc = 0;

    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_ack", {31'b0, ack}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
        end else if (start_id != done_id) begin
            if (!run) begin
                run = 1'b1;
                tcyc = 0;
            end
            chk("ack", {31'b0, ack}, {31'b0, tcyc == exp_lat});
            chk("mem_wr", {31'b0, mem_wr}, {31'b0, tcyc == exp_wr});
            if (lit_en) chk("lit_ack", {31'b0, ack}, {31'b0, tcyc == lit_lat});
            if (tcyc == exp_wr) begin
                chk("mem_addr", mem_addr, exp_base);
                chk("mem_wdata", mem_wdata, exp_wword);
                if (lit_en) chk("lit_wdata", mem_wdata, lit_val);
            end
            if (tcyc == exp_lat) begin
                chk("err", {31'b0, err}, {31'b0, exp_err});
                if (lit_en) chk("lit_err", {31'b0, err}, {31'b0, lit_err});
                if (!exp_err && !exp_we) begin
                    chk("rdata", rdata, exp_rdata);
                    if (lit_en) chk("lit_rdata", rdata, lit_val);
                end
                done_id = start_id;
                run = 1'b0;
            end
            tcyc++;
        end else begin
            chk("idle_ack", {31'b0, ack}, 32'd0);
            chk("idle_mem_wr", {31'b0, mem_wr}, 32'd0);
        end
    end

    logic [7:0] rmem [0:1023];

    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [9:0] a, input logic [31:0] wd);
        int n;
        int b;
        logic [31:0] v;
        n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        b = int'(a) & ~3;
        exp_err = (sz == 2'd3) || (int'(a) % n != 0);
        exp_we = w;
        exp_base = 32'(b);
        exp_wr = 99;
        exp_wword = '0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (w) begin
            for (int i = 0; i < n; i++)
                rmem[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
            exp_wword = {rmem[b], rmem[b+1], rmem[b+2], rmem[b+3]};
            exp_lat = (n == 4) ? 2 : 4;
            exp_wr = exp_lat - 1;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(rmem[int'(a) + i]);
            if (sg && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8 * n));
            exp_rdata = v;
            exp_lat = 3;
        end
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [9:0] a, input logic [31:0] wd,
                          input logic len, input int llat,
                          input logic lerr, input logic [31:0] lval);
        model(w, sz, sg, a, wd);
        lit_en = len;
        lit_lat = llat;
        lit_err = lerr;
        lit_val = lval;
        req = 1'b1;
        we = w;
        size = sz;
        sign = sg;
        addr = {22'b0, a};
        wdata = wd;
        start_id++;
        @(posedge clk);
        #2;
        we = $urandom_range(0, 1);
        size = 2'($urandom_range(0, 3));
        sign = $urandom_range(0, 1);
        addr = $urandom;
        wdata = $urandom;
        wait (done_id == start_id);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [1:0]  sz;
        logic [9:0]  a;
        for (int i = 0; i < 256; i++) begin
            w = init_word(i);
            rmem[4*i]   = w[31:24];
            rmem[4*i+1] = w[23:16];
            rmem[4*i+2] = w[15:8];
            rmem[4*i+3] = w[7:0];
        end
        lit_en = 1'b0;
        reset = 1'b1;
        req = 1'b0;
        we = 1'b0;
        size = 2'b00;
        sign = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        idle(2);

        do_req(1'b0, 2'b10, 1'b1, 10'h101, 32'h0, 1'b1, 3, 1'b0, 32'hffff_ff99);
        idle(1);
        do_req(1'b0, 2'b01, 1'b0, 10'h102, 32'h0, 1'b1, 3, 1'b0, 32'h0000_aabb);
        idle(1);
        do_req(1'b1, 2'b10, 1'b0, 10'h103, 32'hdead_be5a, 1'b1, 4, 1'b0, 32'h8899_aa5a);
        idle(1);
        do_req(1'b0, 2'b00, 1'b0, 10'h100, 32'h0, 1'b1, 3, 1'b0, 32'h8899_aa5a);
        idle(1);
        do_req(1'b1, 2'b01, 1'b0, 10'h101, 32'h1234, 1'b1, 1, 1'b1, 32'h0);
        idle(1);
        do_req(1'b0, 2'b11, 1'b0, 10'h100, 32'h0, 1'b1, 1, 1'b1, 32'h0);
        idle(1);
        do_req(1'b0, 2'b00, 1'b0, 10'h100, 32'h0, 1'b1, 3, 1'b0, 32'h8899_aa5a);
        idle(1);
        do_req(1'b1, 2'b00, 1'b0, 10'h100, 32'h1111_1111, 1'b1, 2, 1'b0, 32'h1111_1111);
        do_req(1'b1, 2'b00, 1'b0, 10'h104, 32'h2222_2222, 1'b1, 2, 1'b0, 32'h2222_2222);
        idle(1);
        do_req(1'b0, 2'b00, 1'b0, 10'h100, 32'h0, 1'b1, 3, 1'b0, 32'h1111_1111);
        do_req(1'b0, 2'b00, 1'b0, 10'h104, 32'h0, 1'b1, 3, 1'b0, 32'h2222_2222);
        idle(1);
        do_req(1'b1, 2'b00, 1'b0, 10'h100, 32'h8899_aabb, 1'b0, 0, 1'b0, 32'h0);
        idle(1);

        // Byte store aborted by reset during its WAIT cycle.
        req = 1'b1;
        we = 1'b1;
        size = 2'b10;
        sign = 1'b0;
        addr = 32'h100;
        wdata = 32'h77;
        @(posedge clk);
        #2;
        req = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        idle(2);
        do_req(1'b0, 2'b00, 1'b0, 10'h100, 32'h0, 1'b1, 3, 1'b0, 32'h8899_aabb);
        idle(1);

        for (int k = 0; k < 400; k++) begin
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = 10'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd0) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, 1'b0, 0, 1'b0, 32'h0);
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-side responder for the multicycle CPU's load/store path. It accepts word, halfword and byte load/store requests from the control unit over a req/ack handshake and turns them into accesses on the word-wide `Memoria`, which has a one-cycle read latency. Sub-word stores use read-modify-write; loads are extracted and sign- or zero-extended. The result goes to the write-data mux in place of the former load-size path.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; only 32 is supported
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- req  in  1  request; held high by the requester until `ack`
- we  in  1  1 = store, 0 = load
- size  in  2  access size code from the shared package
- sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data, right-justified (byte in [7:0], half in [15:0])
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with `ack`: misaligned access or reserved size
- rdata  out  DATA_W  load result, valid with `ack`, held until the next accepted load
- mem_addr  out  ADDR_W  word address to `Memoria` (`addr` with [1:0] forced to 0)
- mem_wr  out  1  memory write strobe
- mem_wdata  out  DATA_W  full word to write
- mem_rdata  in  DATA_W  `Memoria` read data, valid one cycle after `mem_addr`

## Operation
- Memory is big-endian within a word: the byte at offset 0 is bits [31:24].
- Size codes:
  - SZ_WORD = 00, SZ_HALF = 01, SZ_BYTE = 10.
  - 11 is reserved and always gives `err`.
- Alignment rules:
  - A word access needs addr[1:0] = 00.
  - A halfword access needs addr[0] = 0.
  - Bytes are always aligned.
- Requests are latched only in IDLE when `req` = 1. The latched copy of addr, size, we, sign and wdata is used for the whole operation.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE transitions:
  - misaligned or reserved size → DONE with `err`; no memory access is made.
  - word store → WRITE.
  - any other access → READ.
- READ: drive `mem_addr`, `mem_wr` = 0, go to WAIT.
- WAIT: `mem_rdata` is valid in this cycle.
  - Load: register the extracted lane into `rdata`, go to DONE.
  - Sub-word store: register the merged word (selected lane replaced by wdata[7:0] or wdata[15:0], other lanes kept), go to WRITE.
- WRITE: `mem_wr` = 1 and `mem_wdata` = merged word (or wdata for a word store) for exactly one cycle, then DONE.
- DONE: `ack` = 1 for exactly one cycle, then IDLE.
- `req` seen during DONE is ignored. `req` still high in the cycle after `ack` counts as a new request.
- `mem_wr`, `ack` and `err` are decoded from the state (Moore outputs). `mem_addr` is driven from the latched address in every state.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is sampled. `ack` is asserted in:
  - cycle 1 for an error;
  - cycle 2 for a word store;
  - cycle 3 for a load;
  - cycle 4 for a sub-word store.
- Reset values: state IDLE; `ack`, `err`, `mem_wr` = 0; `rdata`, `mem_wdata`, latched address = 0.
- Reset takes priority in every state. `reset` asserted in READ, WAIT or WRITE aborts at the next edge, and `mem_wr` is 0 from that edge on.
  - The write in WRITE is only committed if that cycle completes without reset.
  - No `ack` is produced for an aborted request.
- Throughput: at most one request in flight. A new request can be latched no earlier than the cycle after `ack`.

## Structure
- The shared `cpu_pkg` holds:
  - the size codes SZ_WORD, SZ_HALF, SZ_BYTE;
  - the FSM state encoding (3-bit) for IDLE, READ, WAIT, WRITE, DONE;
  - the constant OFF_MASK = 2'b11.
- Sub-module `mem_lane_mux` (combinational) performs both load extraction and store merging. Its inputs are word, offset, size, sign and wdata; its outputs are the extended load value and the merged store word. The top level holds the FSM and registers only.

## Test plan
- Preload mem[0x100] = 0x8899AABB for all scenarios below.
- Signed byte load: load, SZ_BYTE, sign = 1, addr 0x101 → `ack` in cycle 3, `rdata` = 0xFFFFFF99, `err` = 0, `mem_wr` never asserted.
- Zero-extended halfword load: load, SZ_HALF, sign = 0, addr 0x102 → `rdata` = 0x0000AABB in cycle 3.
- Byte store: store, SZ_BYTE, addr 0x103, wdata 0x5A → one `mem_wr` pulse with `mem_wdata` = 0x8899AA5A and `mem_addr` 0x100, `ack` in cycle 4. A following word load from 0x100 returns 0x8899AA5A.
- Misaligned access: store, SZ_HALF, addr 0x101 → `ack` and `err` in cycle 1, no `mem_wr`, memory unchanged. Also size = 11 at 0x100 → `err`.
- Back-to-back word stores: `req` held high for word stores to 0x100 (0x11111111) then 0x104 (0x22222222) → `ack` at cycles 2 and 5, two `mem_wr` pulses, both words written.
- Reset mid-store: assert `reset` in WAIT of a byte store to 0x100 → no `mem_wr`, no `ack`, state IDLE, mem[0x100] still 0x8899AABB.
